// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard; reads are combinational (0 cycles), writes/reservations commit on the rising edge.
// No backpressure: one write and one reservation are accepted every cycle.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rfwrite,
  input  logic [ADDR_W-1:0]       wadd,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_add,
  input  logic [NREAD*ADDR_W-1:0] radd,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  output logic [DEPTH-1:0]        busy_vec
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic             w_wr_en;
  logic             w_rsv_en;
  logic [DEPTH-1:0] w_busy_nxt;

  assign w_wr_en  = rfwrite && !(ZERO_REG && (wadd == '0));
  assign w_rsv_en = rsv_en  && !(ZERO_REG && (rsv_add == '0));

  // Reservation is applied after the release so a same-address pair ends busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_en)  w_busy_nxt[wadd]    = 1'b0;
    if (w_rsv_en) w_busy_nxt[rsv_add] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_wr_en) r_mem[wadd] <= wdata;
    end
  end

  assign busy_vec = r_busy;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_radd;
    logic              w_zero;
    logic              w_byp;

    assign w_radd = radd[i*ADDR_W +: ADDR_W];
    assign w_zero = ZERO_REG && (w_radd == '0);
    // A write presented during reset is discarded, so it must not be forwarded either.
    assign w_byp  = BYPASS && rst_n && w_wr_en && (wadd == w_radd);

    assign rdata[i*WIDTH +: WIDTH] = w_zero ? '0 : (w_byp ? wdata : r_mem[w_radd]);
    assign rbusy[i]                = !w_zero && !w_byp && r_busy[w_radd];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default, no-bypass and narrow/no-zero-reg instances checked through a scoreboard queue.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus for the default (A) and BYPASS=0 (B) instances
  logic        rfwrite = 1'b0;
  logic [4:0]  wadd = '0;
  logic [31:0] wdata = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_add = '0;
  logic [9:0]  radd = '0;
  logic [63:0] a_rdata, b_rdata;
  logic [1:0]  a_rbusy, b_rbusy;
  logic [31:0] a_bvec, b_bvec;

  // WIDTH=16, DEPTH=8, NREAD=3, ZERO_REG=0 instance (C)
  logic        c_rfwrite = 1'b0;
  logic [2:0]  c_wadd = '0;
  logic [15:0] c_wdata = '0;
  logic        c_rsv_en = 1'b0;
  logic [2:0]  c_rsv_add = '0;
  logic [8:0]  c_radd = '0;
  logic [47:0] c_rdata;
  logic [2:0]  c_rbusy;
  logic [7:0]  c_bvec;

  reg_file_mp u_a (
    .clk(clk), .rst_n(rst_n), .rfwrite(rfwrite), .wadd(wadd), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_add(rsv_add), .radd(radd),
    .rdata(a_rdata), .rbusy(a_rbusy), .busy_vec(a_bvec)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rfwrite(rfwrite), .wadd(wadd), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_add(rsv_add), .radd(radd),
    .rdata(b_rdata), .rbusy(b_rbusy), .busy_vec(b_bvec)
  );

  reg_file_mp #(.WIDTH(16), .DEPTH(8), .NREAD(3), .ZERO_REG(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .rfwrite(c_rfwrite), .wadd(c_wadd), .wdata(c_wdata),
    .rsv_en(c_rsv_en), .rsv_add(c_rsv_add), .radd(c_radd),
    .rdata(c_rdata), .rbusy(c_rbusy), .busy_vec(c_bvec)
  );

  localparam int SA_RD = 0, SA_RB = 1, SA_BV = 2;
  localparam int SB_RD = 3, SB_RB = 4, SB_BV = 5;
  localparam int SC_RD = 6, SC_RB = 7, SC_BV = 8;

  typedef struct {
    int          sel;
    int          port;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   errors = 0;
  int   checks = 0;
  event smp_ev;

  function automatic logic [31:0] actual(input int sel, input int p);
    case (sel)
      SA_RD:   return a_rdata[p*32 +: 32];
      SA_RB:   return {31'h0, a_rbusy[p]};
      SA_BV:   return a_bvec;
      SB_RD:   return b_rdata[p*32 +: 32];
      SB_RB:   return {31'h0, b_rbusy[p]};
      SB_BV:   return b_bvec;
      SC_RD:   return {16'h0, c_rdata[p*16 +: 16]};
      SC_RB:   return {29'h0, c_rbusy};
      SC_BV:   return {24'h0, c_bvec};
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  // Monitor: drains every expectation queued before the sample strobe
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(smp_ev);
      while (q.size() > 0) begin
        c = q.pop_front();
        act = actual(c.sel, c.port);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input int p, input logic [31:0] v, input string nm);
    chk_t c;
    c.sel = sel; c.port = p; c.exp = v; c.name = nm;
    q.push_back(c);
  endtask

  task automatic sample();
    -> smp_ev;
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_radd(input logic [4:0] p0, input logic [4:0] p1);
    radd = {p1, p0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    expect_v(SA_RD, 0, 32'h0, "reset_a_rd0");
    expect_v(SA_RD, 1, 32'h0, "reset_a_rd1");
    expect_v(SA_RB, 0, 32'h0, "reset_a_rbusy0");
    expect_v(SA_BV, 0, 32'h0, "reset_a_bvec");
    expect_v(SC_RD, 2, 32'h0, "reset_c_rd2");
    expect_v(SC_BV, 0, 32'h0, "reset_c_bvec");
    sample();
    rst_n = 1'b1;

    // Fill 1..31 with own index, then reserve 9
    for (int i = 1; i < 32; i++) begin
      rfwrite = 1'b1; wadd = 5'(i); wdata = 32'(i);
      tick();
    end
    rfwrite = 1'b0;
    rsv_en = 1'b1; rsv_add = 5'd9;
    tick();
    rsv_en = 1'b0;
    set_radd(5'd17, 5'd9);
    expect_v(SA_RD, 0, 32'd17, "fill_a_rd17");
    expect_v(SA_RD, 1, 32'd9,  "fill_a_rd9");
    expect_v(SA_RB, 1, 32'h1,  "fill_a_rbusy9");
    expect_v(SA_BV, 0, 32'h0000_0200, "fill_a_bvec");
    expect_v(SB_RD, 0, 32'd17, "fill_b_rd17");
    sample();

    // Asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1;
    expect_v(SA_RD, 0, 32'h0, "async_rst_a_rd0");
    expect_v(SA_RD, 1, 32'h0, "async_rst_a_rd1");
    expect_v(SA_RB, 1, 32'h0, "async_rst_a_rbusy1");
    expect_v(SA_BV, 0, 32'h0, "async_rst_a_bvec");
    expect_v(SB_RD, 0, 32'h0, "async_rst_b_rd0");
    expect_v(SB_BV, 0, 32'h0, "async_rst_b_bvec");
    sample();
    rst_n = 1'b1;

    // Write 20 <- 55
    rfwrite = 1'b1; wadd = 5'd20; wdata = 32'd55;
    tick();
    rfwrite = 1'b0;
    set_radd(5'd20, 5'd20);
    expect_v(SA_RD, 0, 32'd55, "wr20_a_rd0");
    expect_v(SA_RD, 1, 32'd55, "wr20_a_rd1");
    expect_v(SB_RD, 0, 32'd55, "wr20_b_rd0");
    sample();

    // Write to register 0 is ignored, including on the bypass path
    rfwrite = 1'b1; wadd = 5'd0; wdata = 32'd9;
    set_radd(5'd0, 5'd0);
    expect_v(SA_RD, 0, 32'h0, "wr0_bypass_a_rd0");
    expect_v(SA_RB, 0, 32'h0, "wr0_bypass_a_rbusy0");
    sample();
    tick();
    rfwrite = 1'b0;
    expect_v(SA_RD, 0, 32'h0, "wr0_a_rd0");
    expect_v(SA_RD, 1, 32'h0, "wr0_a_rd1");
    expect_v(SB_RD, 0, 32'h0, "wr0_b_rd0");
    sample();

    // Bypass: reg 2 holds 77, then write 9 with same-cycle read
    rfwrite = 1'b1; wadd = 5'd2; wdata = 32'd77;
    tick();
    wdata = 32'd9;
    set_radd(5'd2, 5'd20);
    expect_v(SA_RD, 0, 32'd9,  "bypass_a_rd0");
    expect_v(SB_RD, 0, 32'd77, "nobypass_b_old");
    expect_v(SA_RD, 1, 32'd55, "bypass_a_rd1_other");
    sample();
    tick();
    rfwrite = 1'b0;
    expect_v(SA_RD, 0, 32'd9, "bypass_a_after");
    expect_v(SB_RD, 0, 32'd9, "nobypass_b_after");
    sample();

    // Scoreboard: reserve 5, then release by writing 44
    rsv_en = 1'b1; rsv_add = 5'd5;
    set_radd(5'd5, 5'd2);
    expect_v(SA_RB, 0, 32'h0, "rsv5_same_cycle_rbusy");
    expect_v(SA_BV, 0, 32'h0, "rsv5_same_cycle_bvec");
    sample();
    tick();
    rsv_en = 1'b0;
    expect_v(SA_BV, 0, 32'h0000_0020, "rsv5_a_bvec");
    expect_v(SA_RB, 0, 32'h1, "rsv5_a_rbusy");
    expect_v(SB_RB, 0, 32'h1, "rsv5_b_rbusy");
    sample();
    rfwrite = 1'b1; wadd = 5'd5; wdata = 32'd44;
    expect_v(SA_RB, 0, 32'h0, "rel5_a_rbusy_same");
    expect_v(SA_RD, 0, 32'd44, "rel5_a_rd_same");
    expect_v(SA_BV, 0, 32'h0000_0020, "rel5_a_bvec_same");
    expect_v(SB_RB, 0, 32'h1, "rel5_b_rbusy_same");
    expect_v(SB_RD, 0, 32'h0, "rel5_b_rd_same");
    sample();
    tick();
    rfwrite = 1'b0;
    expect_v(SA_BV, 0, 32'h0, "rel5_a_bvec_after");
    expect_v(SA_RD, 0, 32'd44, "rel5_a_rd_after");
    expect_v(SB_RD, 0, 32'd44, "rel5_b_rd_after");
    expect_v(SB_BV, 0, 32'h0, "rel5_b_bvec_after");
    sample();

    // Reserve and write 7 together: reservation wins
    rsv_en = 1'b1; rsv_add = 5'd7;
    rfwrite = 1'b1; wadd = 5'd7; wdata = 32'h0000_1234;
    set_radd(5'd7, 5'd5);
    expect_v(SA_RD, 0, 32'h0000_1234, "rw7_a_rd_same");
    expect_v(SA_RB, 0, 32'h0, "rw7_a_rbusy_same");
    sample();
    tick();
    rsv_en = 1'b0; rfwrite = 1'b0;
    expect_v(SA_BV, 0, 32'h0000_0080, "rw7_a_bvec");
    expect_v(SA_RD, 0, 32'h0000_1234, "rw7_a_rd");
    expect_v(SA_RB, 0, 32'h1, "rw7_a_rbusy");
    expect_v(SB_BV, 0, 32'h0000_0080, "rw7_b_bvec");
    expect_v(SB_RD, 0, 32'h0000_1234, "rw7_b_rd");
    sample();

    // Reserve 8 while writing 7: both take effect
    rsv_en = 1'b1; rsv_add = 5'd8;
    rfwrite = 1'b1; wadd = 5'd7; wdata = 32'h0000_CAFE;
    tick();
    rsv_en = 1'b0; rfwrite = 1'b0;
    expect_v(SA_BV, 0, 32'h0000_0100, "r8w7_a_bvec");
    expect_v(SA_RD, 0, 32'h0000_CAFE, "r8w7_a_rd");
    expect_v(SA_RB, 0, 32'h0, "r8w7_a_rbusy");
    sample();

    // Reserving register 0 is ignored
    rsv_en = 1'b1; rsv_add = 5'd0;
    tick();
    rsv_en = 1'b0;
    set_radd(5'd0, 5'd8);
    expect_v(SA_BV, 0, 32'h0000_0100, "rsv0_a_bvec");
    expect_v(SA_RB, 0, 32'h0, "rsv0_a_rbusy0");
    expect_v(SA_RB, 1, 32'h1, "rsv0_a_rbusy8");
    sample();

    // Narrow instance without zero register
    c_rfwrite = 1'b1; c_wadd = 3'd0; c_wdata = 16'hBEEF; c_radd = '0;
    expect_v(SC_RD, 0, 32'h0000_BEEF, "c_byp_rd0");
    expect_v(SC_RD, 1, 32'h0000_BEEF, "c_byp_rd1");
    expect_v(SC_RD, 2, 32'h0000_BEEF, "c_byp_rd2");
    sample();
    tick();
    c_rfwrite = 1'b0;
    expect_v(SC_RD, 0, 32'h0000_BEEF, "c_rd0");
    expect_v(SC_RD, 1, 32'h0000_BEEF, "c_rd1");
    expect_v(SC_RD, 2, 32'h0000_BEEF, "c_rd2");
    sample();
    c_rsv_en = 1'b1; c_rsv_add = 3'd0;
    tick();
    c_rsv_en = 1'b0;
    expect_v(SC_BV, 0, 32'h0000_0001, "c_rsv0_bvec");
    expect_v(SC_RB, 0, 32'h0000_0007, "c_rsv0_rbusy");
    sample();

    // Reset pulse with a write and reservation of 3 pending
    rsv_en = 1'b1; rsv_add = 5'd3;
    rfwrite = 1'b1; wadd = 5'd3; wdata = 32'hA5A5_A5A5;
    set_radd(5'd3, 5'd8);
    expect_v(SA_RD, 0, 32'hA5A5_A5A5, "midrst_a_byp");
    sample();
    #1 rst_n = 1'b0;
    #1;
    expect_v(SA_RD, 0, 32'h0, "midrst_a_rd_held");
    expect_v(SA_BV, 0, 32'h0, "midrst_a_bvec_held");
    expect_v(SC_RD, 0, 32'h0, "midrst_c_rd_held");
    expect_v(SC_BV, 0, 32'h0, "midrst_c_bvec_held");
    sample();
    rsv_en = 1'b0; rfwrite = 1'b0;
    rst_n = 1'b1;
    tick();
    expect_v(SA_RD, 0, 32'h0, "midrst_a_rd3");
    expect_v(SA_BV, 0, 32'h0, "midrst_a_bvec");
    expect_v(SA_RB, 0, 32'h0, "midrst_a_rbusy3");
    expect_v(SB_RD, 0, 32'h0, "midrst_b_rd3");
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file with a per-register busy scoreboard, the successor to the fixed 32x32, two-read/one-write `Register` block. It serves the datapath as the architectural register file. It also serves the future pipelined core's hazard logic: an issuing instruction reserves its destination register, and the eventual write-back releases it. Reads are combinational, with optional same-cycle write-to-read bypass. Writes and reservations are committed on the rising clock edge.

## Interface
- `WIDTH`, 32: data width of each register, in bits.
- `DEPTH`, 32: number of registers. Must be a power of two, at least 2.
- `NREAD`, 2: number of independent read ports, at least 1.
- `ZERO_REG`, 1: when 1, register 0 is hardwired to zero and never busy.
- `BYPASS`, 1: when 1, a write in the current cycle is forwarded to matching read ports.
- `ADDR_W`, derived as `$clog2(DEPTH)`. Not overridable.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rfwrite` input 1: write enable.
- `wadd` input ADDR_W: write address.
- `wdata` input WIDTH: write data.
- `rsv_en` input 1: reserve-register strobe; sets the busy bit of `rsv_add`.
- `rsv_add` input ADDR_W: register to reserve.
- `radd` input NREAD*ADDR_W: packed read addresses. Port i occupies bits [i*ADDR_W +: ADDR_W].
- `rdata` output NREAD*WIDTH: packed read data. Port i occupies bits [i*WIDTH +: WIDTH].
- `rbusy` output NREAD: busy flag of the register addressed on each read port.
- `busy_vec` output DEPTH: full scoreboard, bit r equals the busy bit of register r.

## Operation
- Storage: DEPTH x WIDTH register array plus a DEPTH-bit busy array.
- Reset (`rst_n`=0, asynchronous, no clock needed):
  - All registers clear to 0.
  - All busy bits clear to 0.
  - As a result, `rdata`=0, `rbusy`=0 and `busy_vec`=0 while reset is held.
  - Reset asserted mid-operation discards any pending write or reservation in that cycle.
- Write: when `rfwrite`=1 at a rising edge, `wadd` ← `wdata` and the busy bit of `wadd` clears.
- Reserve: when `rsv_en`=1 at a rising edge, the busy bit of `rsv_add` sets. Register data is unchanged.
- Simultaneous write and reserve:
  - Different addresses: both take effect.
  - Same address: data is written and the busy bit ends set (the new reservation wins over the release).
- Register 0 with `ZERO_REG`=1:
  - Writes to 0 are ignored.
  - Reservations of 0 are ignored.
  - Reads of 0 return 0 with `rbusy`=0.
  - `busy_vec[0]` is always 0.
- Read port i, combinational:
  - If `BYPASS`=1 and `rfwrite`=1 and `wadd`==radd_i, and address 0 is not suppressed by `ZERO_REG`: `rdata`_i=`wdata` and `rbusy`_i=0.
  - Otherwise: `rdata`_i = stored value and `rbusy`_i = busy bit of radd_i.
  - `rbusy` ignores a same-cycle `rsv_en`; a reservation becomes visible the cycle after the edge.
- Read ports are fully independent. Any number of ports may address the same register.
- `busy_vec` always reflects the registered busy array. It is not bypassed.
- A write to a non-busy register is legal and needs no reservation. Reserving an already-busy register leaves it busy.

## Timing
- Read latency: 0 cycles (combinational from `radd`, and from `rfwrite`/`wadd`/`wdata` when `BYPASS`=1).
- Write latency:
  - `BYPASS`=1: data is visible on reads in the same cycle.
  - `BYPASS`=0: data is visible in the cycle after the edge.
- Reserve latency: the busy bit is visible one cycle after the `rsv_en` edge.
- Release latency: with `BYPASS`=1, `rbusy` drops in the write cycle; `busy_vec` drops after the edge.
- No handshakes and no stall. One write and one reservation per cycle maximum.

## Test plan
- Reset: fill registers 1..31 with their own index, assert `rst_n`=0 between edges.
  - Required: all `rdata`=0 and `busy_vec`=0 immediately, before any clock edge.
- Write/read, default parameters:
  - `rfwrite`=1, `wadd`=20, `wdata`=55, one edge, then `radd`={20,20}: both ports read 55.
  - `wadd`=0, `wdata`=9: port reads 0.
- Bypass: `rfwrite`=1, `wadd`=2, `wdata`=9 and radd_0=2, all in the same cycle, before the edge.
  - `BYPASS`=1: `rdata`_0=9.
  - `BYPASS`=0: `rdata`_0 = old value; 9 after the edge.
- Scoreboard:
  - Reserve 5: `busy_vec[5]`=1 next cycle, and `rbusy`=1 on a port reading 5.
  - Write 5 with 44: `rbusy`=0 in the same cycle; `busy_vec[5]`=0 after the edge.
  - Reserve and write 7 in the same cycle: busy stays 1 and register 7 holds the new data.
- Parametrisation with `WIDTH`=16, `DEPTH`=8, `NREAD`=3, `ZERO_REG`=0:
  - Write `16'hBEEF` to register 0: reads `16'hBEEF` on all three ports.
  - Reserve 0: `busy_vec[0]`=1.
- Reset mid-operation: reserve 3 and write 3 with `32'hA5A5A5A5`, then pulse `rst_n` low asynchronously.
  - Required: register 3 reads 0 and `busy_vec[3]`=0.
